// File: rtl/eer_rl_pkg.sv
// Shared definitions for the EER-RL cluster-head blocks: word/address
// widths, the shared-memory map and the find_my_best state encoding.
// Optional feature macro: FIND_BEST_HOP_TIEBREAK_EN (adds the RD_HOPS state).
package eer_rl_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int ADDR_WIDTH = 11;

  localparam logic [ADDR_WIDTH-1:0] NCNT_ADDR    = 11'h2B4;
  localparam logic [ADDR_WIDTH-1:0] NBR_ID_BASE  = 11'h072;
  localparam logic [ADDR_WIDTH-1:0] CHQ_BASE     = 11'h052;
  localparam logic [ADDR_WIDTH-1:0] NHOPS_BASE   = 11'h032;
  localparam logic [ADDR_WIDTH-1:0] BEST_CH_ADDR = 11'h2D8;
  localparam logic [ADDR_WIDTH-1:0] BEST_Q_ADDR  = 11'h2DA;

  // Largest neighbour count the tables can hold.
  localparam logic [4:0] MAX_NBR = 5'd16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_NCNT,
    ST_RD_ID,
    ST_RD_Q,
`ifdef FIND_BEST_HOP_TIEBREAK_EN
    ST_RD_HOPS,
`endif
    ST_CMP,
    ST_WR_CH,
    ST_WR_Q,
    ST_DONE
  } fmb_state_t;

  // Byte address of 16-bit table entry idx.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [4:0]            idx
  );
    return base + {5'b0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/find_my_best.sv
// find_my_best: scans the neighbour tables in shared memory, picks the entry
// with the largest unsigned Q and writes its ID and Q back to memory.
// Optional feature macro: FIND_BEST_HOP_TIEBREAK_EN (equal Q resolved by
// fewest hops; adds one read cycle per neighbour).
module find_my_best
  import eer_rl_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done
);

  fmb_state_t            r_state;
  fmb_state_t            w_next;

  logic [4:0]            r_i;
  logic [4:0]            r_n;
  logic [WORD_WIDTH-1:0] r_cand_id;
  logic [WORD_WIDTH-1:0] r_cand_q;
  logic [WORD_WIDTH-1:0] r_best_id;
  logic [WORD_WIDTH-1:0] r_best_q;
  logic                  r_best_valid;
`ifdef FIND_BEST_HOP_TIEBREAK_EN
  logic [WORD_WIDTH-1:0] r_cand_hops;
  logic [WORD_WIDTH-1:0] r_best_hops;
`endif

  logic [4:0]            w_n;
  logic [4:0]            w_i_nxt;
  logic                  w_take;
  logic                  w_wr;
  logic                  w_done;

  assign w_n     = (data_in > {11'b0, MAX_NBR}) ? MAX_NBR : data_in[4:0];
  assign w_i_nxt = r_i + 5'd1;

`ifdef FIND_BEST_HOP_TIEBREAK_EN
  assign w_take = !r_best_valid || (r_cand_q > r_best_q) ||
                  ((r_cand_q == r_best_q) && (r_cand_hops < r_best_hops));
`else
  assign w_take = !r_best_valid || (r_cand_q > r_best_q);
`endif

  // Strobes are masked by nrst so a reset edge never coincides with a write.
  assign wr_en = w_wr & nrst;
  assign done  = w_done & nrst;

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and memory-port outputs; the read address is driven in the
  // cycle before the state that consumes data_in.
  always_comb begin
    w_next   = r_state;
    address  = '0;
    data_out = '0;
    w_wr     = 1'b0;
    w_done   = 1'b0;
    busy     = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (en && start) begin
          address = NCNT_ADDR;
          w_next  = ST_RD_NCNT;
        end
      end
      ST_RD_NCNT: begin
        if (w_n == 5'd0) begin
          w_next = ST_WR_CH;
        end else begin
          address = word_addr(NBR_ID_BASE, r_i);
          w_next  = ST_RD_ID;
        end
      end
      ST_RD_ID: begin
        address = word_addr(CHQ_BASE, r_i);
        w_next  = ST_RD_Q;
      end
      ST_RD_Q: begin
`ifdef FIND_BEST_HOP_TIEBREAK_EN
        address = word_addr(NHOPS_BASE, r_i);
        w_next  = ST_RD_HOPS;
`else
        w_next  = ST_CMP;
`endif
      end
`ifdef FIND_BEST_HOP_TIEBREAK_EN
      ST_RD_HOPS: w_next = ST_CMP;
`endif
      ST_CMP: begin
        if (w_i_nxt == r_n) begin
          w_next = ST_WR_CH;
        end else begin
          address = word_addr(NBR_ID_BASE, w_i_nxt);
          w_next  = ST_RD_ID;
        end
      end
      ST_WR_CH: begin
        address  = BEST_CH_ADDR;
        data_out = r_best_id;
        w_wr     = 1'b1;
        w_next   = ST_WR_Q;
      end
      ST_WR_Q: begin
        address  = BEST_Q_ADDR;
        data_out = r_best_q;
        w_wr     = 1'b1;
        w_next   = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Scan datapath: count, candidate latches and running best entry.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_i          <= '0;
      r_n          <= '0;
      r_cand_id    <= '0;
      r_cand_q     <= '0;
      r_best_id    <= '0;
      r_best_q     <= '0;
      r_best_valid <= 1'b0;
`ifdef FIND_BEST_HOP_TIEBREAK_EN
      r_cand_hops  <= '0;
      r_best_hops  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en && start) begin
            r_i          <= '0;
            r_best_q     <= '0;
            r_best_id    <= '1;
            r_best_valid <= 1'b0;
          end
        end
        ST_RD_NCNT: r_n       <= w_n;
        ST_RD_ID:   r_cand_id <= data_in;
        ST_RD_Q:    r_cand_q  <= data_in;
`ifdef FIND_BEST_HOP_TIEBREAK_EN
        ST_RD_HOPS: r_cand_hops <= data_in;
`endif
        ST_CMP: begin
          if (w_take) begin
            r_best_id    <= r_cand_id;
            r_best_q     <= r_cand_q;
            r_best_valid <= 1'b1;
`ifdef FIND_BEST_HOP_TIEBREAK_EN
            r_best_hops  <= r_cand_hops;
`endif
          end
          r_i <= w_i_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_find_my_best.sv
// Self-checking bench for find_my_best: a synchronous-read memory model
// feeds the DUT, expected write-backs are queued per scan and popped as the
// DUT writes them.
module tb_find_my_best;
  import eer_rl_pkg::*;

`ifdef FIND_BEST_HOP_TIEBREAK_EN
  localparam int PER_NBR = 4;
  localparam bit HOP_TB  = 1'b1;
`else
  localparam int PER_NBR = 3;
  localparam bit HOP_TB  = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  nrst;
  logic                  en;
  logic                  start;
  logic [WORD_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  done;

  find_my_best dut (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .start    (start),
    .data_in  (data_in),
    .address  (address),
    .wr_en    (wr_en),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Memory read data is valid the cycle after the address.
  logic [15:0] tbl [0:1023];
  always @(posedge clk) data_in <= tbl[address[10:1]];

  typedef struct {
    logic [10:0] a;
    logic [15:0] d;
  } wr_t;
  wr_t sbq[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int done_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock; observe write strobes and done at the falling edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (wr_en) begin
      if (sbq.size() == 0) begin
        check("unexpected_wr", {21'b0, address}, 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        check("wr_addr", {21'b0, address}, {21'b0, e.a});
        check("wr_data", {16'b0, data_out}, {16'b0, e.d});
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic set_ent(input int k, input logic [15:0] id, input logic [15:0] q,
                         input logic [15:0] h);
    tbl[(NBR_ID_BASE >> 1) + k] = id;
    tbl[(CHQ_BASE >> 1) + k]    = q;
    tbl[(NHOPS_BASE >> 1) + k]  = h;
  endtask

  // Reference selection over the first min(n,16) entries.
  task automatic model(input int nraw, output logic [15:0] id, output logic [15:0] q);
    int nn;
    logic [15:0] bh, cq, ch;
    bit v;
    nn = (nraw > 16) ? 16 : nraw;
    id = 16'hFFFF; q = 16'h0; bh = 16'h0; v = 1'b0;
    for (int k = 0; k < nn; k++) begin
      cq = tbl[(CHQ_BASE >> 1) + k];
      ch = tbl[(NHOPS_BASE >> 1) + k];
      if (!v || cq > q || (HOP_TB && cq == q && ch < bh)) begin
        id = tbl[(NBR_ID_BASE >> 1) + k];
        q  = cq;
        bh = ch;
        v  = 1'b1;
      end
    end
  endtask

  task automatic do_scan(input int nraw, input logic [15:0] eid, input logic [15:0] eq,
                         input bit glitch);
    int sc, d0, nn;
    wr_t e;
    nn = (nraw > 16) ? 16 : nraw;
    tbl[NCNT_ADDR >> 1] = nraw[15:0];
    e.a = BEST_CH_ADDR; e.d = eid; sbq.push_back(e);
    e.a = BEST_Q_ADDR;  e.d = eq;  sbq.push_back(e);
    d0 = n_done;
    start = 1'b1;
    sc = cyc;
    #1 check("start_addr", {21'b0, address}, {21'b0, NCNT_ADDR});
    tick();
    start = 1'b0;
    check("busy_running", {31'b0, busy}, 32'd1);
    for (int k = 0; k < 300 && n_done == d0; k++) begin
      start = glitch && (k % 3 == 0);
      tick();
    end
    start = 1'b0;
    if (n_done == d0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", done_cyc - sc + 1, PER_NBR * nn + 5);
    end
    tick();
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_addr", {21'b0, address}, 32'd0);
    check("done_count", n_done - d0, 32'd1);
    check("sb_empty", sbq.size(), 32'd0);
  endtask

  initial begin
    logic [15:0] mid, mq;
    int rn, d0;
    for (int k = 0; k < 1024; k++) tbl[k] = 16'h0;
    nrst = 1'b0; en = 1'b1; start = 1'b0;
    repeat (3) tick();
    check("rst_addr", {21'b0, address}, 32'd0);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_data_out", {16'b0, data_out}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    nrst = 1'b1;
    tick();

    // start ignored while disabled
    en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("en0_busy", {31'b0, busy}, 32'd0);
    en = 1'b1;

    // case 1
    set_ent(0, 16'd5, 16'h0100, 16'd2);
    set_ent(1, 16'd9, 16'h0300, 16'd2);
    set_ent(2, 16'd12, 16'h0200, 16'd2);
    do_scan(3, 16'd9, 16'h0300, 1'b0);

    // case 2
    do_scan(0, 16'hFFFF, 16'h0000, 1'b0);

    // case 3
    set_ent(0, 16'd21, 16'h0200, 16'd3);
    set_ent(1, 16'd33, 16'h0200, 16'd1);
    do_scan(2, HOP_TB ? 16'd33 : 16'd21, 16'h0200, 1'b0);

    // case 4: n clamped to 16, larger Q beyond the table end
    for (int k = 0; k < 16; k++)
      set_ent(k, 16'(100 + k), 16'(16 * k + 1), 16'(k));
    tbl[(CHQ_BASE >> 1) + 7]  = 16'h0F00;
    tbl[(CHQ_BASE >> 1) + 17] = 16'hF000;
    do_scan(20, 16'd107, 16'h0F00, 1'b0);

    // case 5: reset in cycle 5 of an n=4 scan
    for (int k = 0; k < 4; k++) set_ent(k, 16'(40 + k), 16'(k + 1), 16'd0);
    tbl[NCNT_ADDR >> 1] = 16'd4;
    d0 = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    nrst = 1'b0;
    tick();
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_addr", {21'b0, address}, 32'd0);
    check("abort_wr_en", {31'b0, wr_en}, 32'd0);
    check("abort_data_out", {16'b0, data_out}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    nrst = 1'b1;
    repeat (20) tick();
    check("abort_no_done", n_done - d0, 32'd0);
    check("abort_no_wr", sbq.size(), 32'd0);
    do_scan(4, 16'd43, 16'd4, 1'b0);

    // case 6: start pulsed while busy
    set_ent(0, 16'd5, 16'h0100, 16'd2);
    set_ent(1, 16'd9, 16'h0300, 16'd2);
    set_ent(2, 16'd12, 16'h0200, 16'd2);
    do_scan(3, 16'd9, 16'h0300, 1'b1);

    // random tables with frequent Q ties
    for (int t = 0; t < 6; t++) begin
      rn = $urandom_range(1, 16);
      for (int k = 0; k < 16; k++)
        set_ent(k, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 7) * 256),
                16'($urandom_range(0, 3)));
      model(rn, mid, mq);
      do_scan(rn, mid, mq, t[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
